// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the round-robin arbiter and the async FIFO write side.
// The master modport is the arbiter's view of the bundle.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int FIFO_DATA_WIDTH = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               winc;
  logic [FIFO_DATA_WIDTH-1:0]         wdata;
  logic                               wfull;
  logic [GW-1:0]                      grant_id;
  logic                               busy;

  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port among NUM_REQ producers.
// A grant holds until a last beat or MAX_BURST beats; one idle cycle is spent per arbitration.
module fifo_wr_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int MAX_BURST       = 16
) (
  input  logic               wclk,
  input  logic               wrst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                     state_r, state_s;
  logic [GW-1:0]              grant_id_r, grant_id_s;
  logic [GW-1:0]              last_grant_r, last_grant_s;
  logic [CW-1:0]              beat_cnt_r, beat_cnt_s;

  logic                       busy_s;
  logic                       xfer_s;
  logic                       end_s;
  logic                       found_s;
  logic [GW-1:0]              pick_s;
  logic [GW:0]                cand_sum_s;
  logic [GW-1:0]              cand_s;
  logic                       sel_valid_s;
  logic                       sel_last_s;
  logic [FIFO_DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_REQ-1:0]         ready_s;

  assign busy_s      = (state_r == BURST);
  assign sel_valid_s = bus.req_valid[grant_id_r];
  assign sel_last_s  = bus.req_last[grant_id_r];
  assign sel_data_s  = bus.req_data[grant_id_r*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
  assign xfer_s      = busy_s & sel_valid_s & ~bus.wfull;
  assign end_s       = sel_last_s | (beat_cnt_r == CW'(MAX_BURST - 1));

  // Round-robin search starting just after the previous winner, wrapping modulo NUM_REQ.
  always_comb begin
    found_s    = 1'b0;
    pick_s     = '0;
    cand_sum_s = '0;
    cand_s     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum_s = {1'b0, last_grant_r} + (GW+1)'(k);
      if (cand_sum_s >= (GW+1)'(NUM_REQ)) begin
        cand_s = GW'(cand_sum_s - (GW+1)'(NUM_REQ));
      end else begin
        cand_s = GW'(cand_sum_s);
      end
      if (!found_s && bus.req_valid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the IDLE/BURST grant FSM.
  always_comb begin
    state_s      = state_r;
    grant_id_s   = grant_id_r;
    last_grant_s = last_grant_r;
    beat_cnt_s   = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_id_s = pick_s;
          beat_cnt_s = '0;
          state_s    = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (xfer_s && end_s) begin
          last_grant_s = grant_id_r;
          beat_cnt_s   = '0;
          state_s      = IDLE;
        end else if (xfer_s) begin
          beat_cnt_s = beat_cnt_r + CW'(1);
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, grant and burst counter registers.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_r      <= IDLE;
      grant_id_r   <= '0;
      last_grant_r <= GW'(NUM_REQ - 1);
      beat_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      grant_id_r   <= grant_id_s;
      last_grant_r <= last_grant_s;
      beat_cnt_r   <= beat_cnt_s;
    end
  end

  // Only the granted requester sees ready, and only while the FIFO has room.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = busy_s & (grant_id_r == GW'(i)) & ~bus.wfull;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.winc      = xfer_s;
  assign bus.wdata     = xfer_s ? sel_data_s : {FIFO_DATA_WIDTH{1'b0}};
  assign bus.grant_id  = grant_id_r;
  assign bus.busy      = busy_s;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat queues drive the producers and a
// scoreboard of expected (data, grant) pairs is consumed on every FIFO write.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [W-1:0] data; logic [1:0] gid; } exp_t;

  logic wclk = 1'b0;
  logic wrst;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_DATA_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  beat_t    pq[N][$];
  exp_t     sb[$];
  int       wcyc[$];
  int       cyc;
  int       nchecks;
  int       nerr;
  logic [N-1:0] acc;
  bit       force_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [N*W-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        v[i]         = 1'b1;
        l[i]         = pq[i][0].last;
        d[i*W +: W]  = pq[i][0].data;
      end
    end
    if (force_all) v = '1;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  // pre: drive inputs and move to the falling edge, where outputs are stable
  task automatic pre();
    drive();
    #4;
  endtask

  // post: score any FIFO write, latch accepted beats, cross the rising edge
  task automatic post();
    exp_t e;
    if (bus.winc === 1'b1) begin
      wcyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_winc", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wdata", 32'(bus.wdata), 32'(e.data));
        chk("grant_id", 32'(bus.grant_id), 32'(e.gid));
      end
    end
    acc = bus.req_ready;
    @(posedge wclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    end
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic push_pkt(input int r, input int n, input logic [W-1:0] base);
    beat_t b;
    for (int j = 0; j < n; j++) begin
      b.data = base + W'(j);
      b.last = (j == n - 1);
      pq[r].push_back(b);
    end
  endtask

  task automatic sb_push(input int r, input int n, input logic [W-1:0] base);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.data = base + W'(j);
      e.gid  = 2'(r);
      sb.push_back(e);
    end
  endtask

  function automatic bit all_empty();
    bit emp;
    emp = (sb.size() == 0);
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) emp = 1'b0;
    return emp;
  endfunction

  task automatic run(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      cycle();
      n++;
    end
    if (!all_empty()) chk({tag, "_timeout"}, 32'd0, 32'd1);
    cycle();
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) pq[i].delete();
    sb.delete();
    wcyc.delete();
  endtask

  task automatic reset_dut();
    clear_all();
    bus.wfull = 1'b0;
    wrst = 1'b1;
    cycle();
    cycle();
    wrst = 1'b0;
  endtask

  initial begin
    nchecks = 0; nerr = 0; cyc = 0; force_all = 1'b0;
    wrst = 1'b1;
    bus.wfull = 1'b0;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    @(posedge wclk);
    #1;

    // 1: reset held with every requester valid
    force_all = 1'b1;
    for (int c = 0; c < 6; c++) begin
      pre();
      chk("t1_winc", 32'(bus.winc), 32'd0);
      chk("t1_ready", 32'(bus.req_ready), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      chk("t1_gid", 32'(bus.grant_id), 32'd0);
      post();
    end
    force_all = 1'b0;

    // 2: single 3-beat packet from requester 2
    reset_dut();
    push_pkt(2, 3, 8'h41);
    sb_push(2, 3, 8'h41);
    pre();
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);
    chk("t2_idle_winc", 32'(bus.winc), 32'd0);
    post();
    for (int c = 0; c < 3; c++) begin
      pre();
      chk("t2_busy", 32'(bus.busy), 32'd1);
      chk("t2_winc", 32'(bus.winc), 32'd1);
      chk("t2_ready", 32'(bus.req_ready), 32'h4);
      post();
    end
    pre();
    chk("t2_done_busy", 32'(bus.busy), 32'd0);
    chk("t2_done_winc", 32'(bus.winc), 32'd0);
    post();

    // 3: round robin over four 2-beat packets, then requester 0 again
    reset_dut();
    push_pkt(0, 2, 8'h00); push_pkt(1, 2, 8'h10);
    push_pkt(2, 2, 8'h20); push_pkt(3, 2, 8'h30);
    push_pkt(0, 2, 8'h08);
    sb_push(0, 2, 8'h00); sb_push(1, 2, 8'h10);
    sb_push(2, 2, 8'h20); sb_push(3, 2, 8'h30);
    sb_push(0, 2, 8'h08);
    run("t3", 100);
    chk("t3_beats", 32'(wcyc.size()), 32'd10);
    for (int k = 1; k < wcyc.size(); k++) begin
      chk("t3_gap", 32'(wcyc[k] - wcyc[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);
    end

    // 4: burst cap splits a 20-beat packet around requester 3
    reset_dut();
    push_pkt(1, 20, 8'h10);
    push_pkt(3, 2, 8'h80);
    sb_push(1, 16, 8'h10);
    sb_push(3, 2, 8'h80);
    sb_push(1, 4, 8'h20);
    run("t4", 200);
    chk("t4_beats", 32'(wcyc.size()), 32'd22);

    // 5: wfull stall for 5 cycles after two beats
    reset_dut();
    push_pkt(0, 6, 8'h50);
    sb_push(0, 6, 8'h50);
    cycle(); cycle(); cycle();
    bus.wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      pre();
      chk("t5_winc", 32'(bus.winc), 32'd0);
      chk("t5_ready", 32'(bus.req_ready), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd1);
      chk("t5_cnt", 32'(dut.beat_cnt_r), 32'd2);
      post();
    end
    bus.wfull = 1'b0;
    run("t5", 50);
    chk("t5_beats", 32'(wcyc.size()), 32'd6);

    // 6: reset during beat 2 of 5, then requester 0 must win over requester 2
    reset_dut();
    push_pkt(1, 1, 8'h5a);
    sb_push(1, 1, 8'h5a);
    run("t6a", 20);
    push_pkt(0, 5, 8'h60);
    sb_push(0, 1, 8'h60);
    cycle(); cycle();
    wrst = 1'b1;
    pre();
    chk("t6_winc", 32'(bus.winc), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_ready", 32'(bus.req_ready), 32'd0);
    chk("t6_gid", 32'(bus.grant_id), 32'd0);
    post();
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);
    clear_all();
    cycle();
    wrst = 1'b0;
    push_pkt(2, 2, 8'h70);
    push_pkt(0, 2, 8'h78);
    sb_push(0, 2, 8'h78);
    sb_push(2, 2, 8'h70);
    run("t6b", 50);
    chk("t6_beats", 32'(wcyc.size()), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
